pwm_duty_ramp: RTL and testbench

//   Upstream command stage for the 21-bit PWM generator. Accepts a (target duty, step, period)

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_tick_gen.sv | 33 +++
 rtl/pwm_duty_ramp.sv | 143 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM command path.
//   state_e            ramp controller states (IDLE/RAMP/DONE)
//   PWM_W              default duty/period width of the PWM stage
//   PWM_DEFAULT_PERIOD pwm_period value after reset
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PWM_W              = 21;
  localparam int PWM_DEFAULT_PERIOD = 1999;

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: ramp-rate prescaler.
//   clk       in  system clock
//   reset_p   in  async active-high reset
//   clr_i     in  restart the prescaler (count returns to 0)
//   tick_o    out 1-cycle pulse every PRESC cycles
// After a clr the first tick is seen in the PRESC-th cycle, so the event it
// triggers lands on the PRESC-th edge after the clearing edge.
module pwm_tick_gen #(
  parameter int PRESC = 4
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(PRESC - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: command stage ahead of the PWM generator. Takes a
// (target, step, period) command over valid/ready and slews duty toward the
// target by <step> counts per ramp tick.
//   clk, reset_p         clock, async active-high reset
//   cmd_valid_i/ready_o  command handshake (ready only in IDLE)
//   cmd_target_i         requested final duty
//   cmd_step_i           duty change per tick (0 = jump on first tick)
//   cmd_period_i         PWM period (counter runs 0..period)
//   abort_i              stop the ramp, freeze duty
//   duty_o, pwm_period_o registered values to the PWM stage
//   busy_o               high in RAMP and DONE
//   done_o               1-cycle pulse when duty reaches the target
// Optional macro PWM_DUTY_RAMP_IRQ_EN adds irq_o (sticky, set by done) and
// irq_clr_i; set wins over clear in the same cycle.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int TICK_HZ        = 10_000,
  parameter int W              = PWM_W,
  parameter int DEFAULT_PERIOD = PWM_DEFAULT_PERIOD
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [W-1:0] cmd_target_i,
  input  logic [W-1:0] cmd_step_i,
  input  logic [W-1:0] cmd_period_i,
  input  logic         abort_i,
  output logic [W-1:0] duty_o,
  output logic [W-1:0] pwm_period_o,
  output logic         busy_o,
`ifdef PWM_DUTY_RAMP_IRQ_EN
  output logic         irq_o,
  input  logic         irq_clr_i,
`endif
  output logic         done_o
);

  localparam int PRESC = (SYS_CLK_FREQ / TICK_HZ > 0) ? SYS_CLK_FREQ / TICK_HZ : 1;

  state_e       state_q, state_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] step_q, step_d;

  logic         accept;
  logic         tick;
  logic         up;
  logic [W-1:0] diff;
  logic [W-1:0] plim;

  assign accept = cmd_valid_i && (state_q == ST_IDLE);

  pwm_tick_gen #(.PRESC(PRESC)) u_tick (
    .clk    (clk),
    .reset_p(reset_p),
    .clr_i  (accept),
    .tick_o (tick)
  );

  // period+1 saturates so an all-ones period can never wrap the duty ceiling
  assign plim = (&cmd_period_i) ? cmd_period_i : cmd_period_i + W'(1);

  // distance is taken before stepping, so the update never wraps or overshoots
  assign up   = (tgt_q > duty_q);
  assign diff = up ? (tgt_q - duty_q) : (duty_q - tgt_q);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    period_d = period_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          period_d = cmd_period_i;
          tgt_d    = (cmd_target_i < plim) ? cmd_target_i : plim;
          step_d   = cmd_step_i;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // abort takes priority over a coincident tick
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if ((step_q == '0) || (diff <= step_q)) begin
            duty_d  = tgt_q;
            state_d = ST_DONE;
          end else begin
            duty_d = up ? (duty_q + step_q) : (duty_q - step_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      period_q <= W'(DEFAULT_PERIOD);
      tgt_q    <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_RAMP) || (state_q == ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign duty_o       = duty_q;
  assign pwm_period_o = period_q;

`ifdef PWM_DUTY_RAMP_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (irq_clr_i) irq_d = 1'b0;
    if (done_o)    irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

  localparam int W     = 21;
  localparam int PRESC = 4;
  localparam longint MAXV = 2097151;

  logic         clk = 1'b0;
  logic         reset_p = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_target = '0;
  logic [W-1:0] cmd_step = '0;
  logic [W-1:0] cmd_period = '0;
  logic         abort = 1'b0;
  logic [W-1:0] duty;
  logic [W-1:0] pwm_period;
  logic         busy;
  logic         done;
`ifdef PWM_DUTY_RAMP_IRQ_EN
  logic         irq;
  logic         irq_clr = 1'b0;
`endif

  pwm_duty_ramp #(.SYS_CLK_FREQ(100), .TICK_HZ(25), .W(W), .DEFAULT_PERIOD(1999)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_target_i(cmd_target),
    .cmd_step_i  (cmd_step),
    .cmd_period_i(cmd_period),
    .abort_i     (abort),
    .duty_o      (duty),
    .pwm_period_o(pwm_period),
    .busy_o      (busy),
`ifdef PWM_DUTY_RAMP_IRQ_EN
    .irq_o       (irq),
    .irq_clr_i   (irq_clr),
`endif
    .done_o      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  // Behavioural model: phase 0 waiting for a command, 1 ramping, 2 reporting
  // completion. Ticks come every PRESC edges counted from the accept edge.
  int      m_phase = 0;
  int      m_wait  = 0;
  longint  m_duty = 0, m_period = 1999, m_tgt = 0, m_step = 0;
  bit      m_acc = 0;
  bit      m_irq = 0;
  longint  m_seq[$];

  always @(posedge clk or posedge reset_p) begin
    m_acc = 0;
    if (reset_p) begin
      m_phase = 0; m_duty = 0; m_period = 1999; m_irq = 0;
    end else begin
`ifdef PWM_DUTY_RAMP_IRQ_EN
      if (m_phase == 2) m_irq = 1;
      else if (irq_clr) m_irq = 0;
`endif
      case (m_phase)
        0: if (cmd_valid) begin
          longint lim;
          m_period = longint'(cmd_period);
          lim = (m_period + 1 > MAXV) ? MAXV : m_period + 1;
          m_tgt  = (longint'(cmd_target) < lim) ? longint'(cmd_target) : lim;
          m_step = longint'(cmd_step);
          m_wait = PRESC;
          m_phase = 1;
          m_acc = 1;
        end
        1: if (abort) m_phase = 0;
           else begin
             m_wait--;
             if (m_wait == 0) begin
               longint d, ad;
               m_wait = PRESC;
               d  = m_tgt - m_duty;
               ad = (d < 0) ? -d : d;
               if (m_step == 0 || ad <= m_step) begin
                 m_duty = m_tgt; m_phase = 2;
               end else m_duty = m_duty + ((d > 0) ? m_step : -m_step);
               m_seq.push_back(m_duty);
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset_p) begin
      logic [W-1:0] e_duty, e_per;
      logic e_rdy, e_busy, e_done, e_irq, a_irq;
      e_duty = W'(m_duty); e_per = W'(m_period);
      e_rdy = (m_phase == 0); e_busy = (m_phase != 0); e_done = (m_phase == 2);
      e_irq = m_irq; a_irq = m_irq;
`ifdef PWM_DUTY_RAMP_IRQ_EN
      a_irq = irq;
`endif
      n_tests++;
      if (duty !== e_duty || pwm_period !== e_per || cmd_ready !== e_rdy ||
          busy !== e_busy || done !== e_done || a_irq !== e_irq) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got duty=%0d per=%0d rdy=%b busy=%b done=%b irq=%b, want duty=%0d per=%0d rdy=%b busy=%b done=%b irq=%b",
                 $time, duty, pwm_period, cmd_ready, busy, done, a_irq,
                 e_duty, e_per, e_rdy, e_busy, e_done, e_irq);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name, input longint exp[$]);
    check({name, "_len"}, m_seq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < m_seq.size(); i++)
      check(name, m_seq[i], exp[i]);
  endtask

  task automatic send(input longint t, input longint s, input longint p);
    bit ok;
    ok = 0;
    cmd_target = W'(t); cmd_step = W'(s); cmd_period = W'(p);
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (m_acc) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (m_phase == 0) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic wait_duty(input longint v);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (m_duty == v && m_wait == 1) begin ok = 1; break; end
    end
    check("wait_duty_timeout", ok, 1);
  endtask

  longint q_up[$]   = '{10, 20, 30, 40, 50};
  longint q_down[$] = '{30, 10, 5};
  longint q_clamp[$] = '{100};
  longint q_same[$] = '{30};
  int d0;

  initial begin
    #12;
    check("rst_duty_held", duty, 0);
    check("rst_busy_held", busy, 0);
    #10 reset_p = 1'b0;
    #1;
    check("rst_duty", duty, 0);
    check("rst_period", pwm_period, 1999);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #2;

    // up ramp
    m_seq.delete(); d0 = done_cnt;
    send(50, 10, 99);
    wait_idle();
    check_seq("up_seq", q_up);
    check("up_duty", duty, 50);
    check("up_ready", cmd_ready, 1);
    check("up_done_cnt", done_cnt - d0, 1);
`ifdef PWM_DUTY_RAMP_IRQ_EN
    check("irq_after_done", irq, 1);
    @(posedge clk); #2;
    check("irq_sticky", irq, 1);
    irq_clr = 1'b1; @(posedge clk); #2; irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
`endif

    // down ramp, non-multiple step
    m_seq.delete(); d0 = done_cnt;
    send(5, 20, 99);
    wait_idle();
    check_seq("down_seq", q_down);
    check("down_duty", duty, 5);
    check("down_done_cnt", done_cnt - d0, 1);

    // clamp to period+1 with a jump
    m_seq.delete();
    send(500, 0, 99);
    wait_idle();
    check_seq("clamp_seq", q_clamp);
    check("clamp_duty", duty, 100);
    check("clamp_period", pwm_period, 99);

    // back to zero, then abort mid ramp with a command held behind it
    send(0, 0, 99);
    wait_idle();
    m_seq.delete(); d0 = done_cnt;
    send(80, 10, 99);
    fork
      send(30, 5, 99);
      begin
        wait_duty(30);
        abort = 1'b1;           // coincides with a tick: must not update
        @(posedge clk); #2;
        abort = 1'b0;
        check("abort_duty", duty, 30);
        check("abort_busy", busy, 0);
        check("abort_no_done", done_cnt - d0, 0);
`ifdef PWM_DUTY_RAMP_IRQ_EN
        irq_clr = 1'b1;
`endif
      end
    join
    // held command targets the frozen duty: completes on the first tick
    m_seq.delete(); d0 = done_cnt;
    wait_idle();
    check_seq("same_seq", q_same);
    check("same_done_cnt", done_cnt - d0, 1);
`ifdef PWM_DUTY_RAMP_IRQ_EN
    check("irq_set_wins", irq, 1);
    irq_clr = 1'b0;
`endif

    // all-ones period: saturated ceiling
    send(MAXV, 0, MAXV);
    wait_idle();
    check("sat_duty", duty, MAXV);
    check("sat_period", pwm_period, MAXV);

    // reset mid-ramp
    send(0, 0, 99);
    wait_idle();
    d0 = done_cnt;
    send(80, 10, 99);
    wait_duty(40);
    #1 reset_p = 1'b1;
    #1;
    check("midrst_duty", duty, 0);
    check("midrst_period", pwm_period, 1999);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #2 reset_p = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_hold_duty", duty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
